// File: rtl/lift_car_model.sv
// Plant model of an elevator car driven by one-hot controller commands: tracks floor travel and
// door motion with tick counters and latches the first illegal command sequence as a fault.
module lift_car_model #(
  parameter int unsigned NUM_FLOORS      = 8,
  parameter int unsigned FLOOR_W         = 3,
  parameter int unsigned TICKS_PER_FLOOR = 4,
  parameter int unsigned DOOR_TICKS      = 3,
  parameter int unsigned CNT_W           = 7,
  parameter int unsigned RESET_FLOOR     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up,
  input  logic               down,
  input  logic               open,
  input  logic               close,
  output logic [FLOOR_W-1:0] floor,
  output logic               arrived,
  output logic               moving,
  output logic               door_open,
  output logic               door_closed,
  output logic               fault,
  output logic [2:0]         fault_code
);

  typedef enum logic [2:0] {
    StStop,
    StMoveUp,
    StMoveDown,
    StDoorOpening,
    StDoorOpen,
    StDoorClosing,
    StFault
  } state_e;

  localparam logic [FLOOR_W-1:0] TopFloor   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] FloorReset = FLOOR_W'(RESET_FLOOR);
  localparam logic [CNT_W-1:0]   CntMove    = CNT_W'(TICKS_PER_FLOOR - 1);
  localparam logic [CNT_W-1:0]   CntDoor    = CNT_W'(DOOR_TICKS - 1);
  localparam logic [2:0]         CodeMulti  = 3'd1;
  localparam logic [2:0]         CodeDoor   = 3'd2;
  localparam logic [2:0]         CodeLimit  = 3'd3;
  localparam logic [2:0]         CodeStray  = 3'd4;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FLOOR_W-1:0]   floor_q, floor_d;
  logic                 arrived_q, arrived_d;
  logic [2:0]           code_q, code_d;
  logic [2:0]           num_cmds;
  logic                 multi_cmd;
  logic                 at_floor;

  assign num_cmds  = {2'b00, up} + {2'b00, down} + {2'b00, open} + {2'b00, close};
  assign multi_cmd = (num_cmds > 3'd1);
  // A moving car sitting exactly on a floor boundary decodes commands like a stopped car.
  assign at_floor  = (state_q == StStop) || (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StStop;
      cnt_q     <= '0;
      floor_q   <= FloorReset;
      arrived_q <= 1'b0;
      code_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      floor_q   <= floor_d;
      arrived_q <= arrived_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    floor_d   = floor_q;
    arrived_d = 1'b0;
    code_d    = code_q;
    if (state_q != StFault && multi_cmd) begin
      state_d = StFault;
      code_d  = CodeMulti;
    end else begin
      case (state_q)
        StStop, StMoveUp, StMoveDown: begin
          if (at_floor) begin
            if (up) begin
              if (floor_q == TopFloor) begin
                state_d = StFault;
                code_d  = CodeLimit;
              end else if (state_q == StMoveUp) begin
                cnt_d = cnt_q + CNT_W'(1);
              end else begin
                state_d = StMoveUp;
                cnt_d   = '0;
              end
            end else if (down) begin
              if (floor_q == '0) begin
                state_d = StFault;
                code_d  = CodeLimit;
              end else if (state_q == StMoveDown) begin
                cnt_d = cnt_q + CNT_W'(1);
              end else begin
                state_d = StMoveDown;
                cnt_d   = '0;
              end
            end else if (open) begin
              state_d = StDoorOpening;
              cnt_d   = '0;
            end else begin
              state_d = StStop;
              cnt_d   = '0;
            end
          end else if ((state_q == StMoveUp && up) || (state_q == StMoveDown && down)) begin
            if (cnt_q == CntMove) begin
              floor_d   = (state_q == StMoveUp) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
              cnt_d     = '0;
              arrived_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = StFault;
            code_d  = CodeStray;
          end
        end
        StDoorOpening: begin
          if (up || down) begin
            state_d = StFault;
            code_d  = CodeDoor;
          end else if (cnt_q == CntDoor) begin
            state_d = StDoorOpen;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StDoorOpen: begin
          if (up || down) begin
            state_d = StFault;
            code_d  = CodeDoor;
          end else if (close) begin
            state_d = StDoorClosing;
            cnt_d   = '0;
          end
        end
        StDoorClosing: begin
          if (up || down) begin
            state_d = StFault;
            code_d  = CodeDoor;
          end else if (open) begin
            // Reversal restarts a full opening stroke, even on the final closing tick.
            state_d = StDoorOpening;
            cnt_d   = '0;
          end else if (cnt_q == CntDoor) begin
            state_d = StStop;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StFault: ;
        default: begin
          state_d = StStop;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    floor       = floor_q;
    arrived     = arrived_q;
    fault_code  = code_q;
    moving      = (state_q == StMoveUp) || (state_q == StMoveDown);
    door_open   = (state_q == StDoorOpen);
    door_closed = (state_q == StStop) || (state_q == StMoveUp) || (state_q == StMoveDown);
    fault       = (state_q == StFault);
  end

endmodule

// File: tb/tb_lift_car_model.sv
// Closed-loop bench for lift_car_model: directed scenarios then random commands, each cycle
// compared against a position/door-stroke reference model.
module tb_lift_car_model;

  localparam int NF  = 8;
  localparam int FW  = 3;
  localparam int TPF = 4;
  localparam int DT  = 3;
  localparam int CW  = 7;
  localparam int RF  = 0;

  logic          clk = 1'b0;
  logic          rst, up, down, open, close;
  logic [FW-1:0] floor;
  logic          arrived, moving, door_open, door_closed, fault;
  logic [2:0]    fault_code;

  lift_car_model #(
    .NUM_FLOORS     (NF),
    .FLOOR_W        (FW),
    .TICKS_PER_FLOOR(TPF),
    .DOOR_TICKS     (DT),
    .CNT_W          (CW),
    .RESET_FLOOR    (RF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up),
    .down       (down),
    .open       (open),
    .close      (close),
    .floor      (floor),
    .arrived    (arrived),
    .moving     (moving),
    .door_open  (door_open),
    .door_closed(door_closed),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: car position as floor plus ticks travelled in direction m_dir, door as a stroke
  // position 0 (shut) .. DT (fully open) moving in m_door_dir; m_code != 0 means faulted.
  int m_floor, m_dir, m_prog, m_door_pos, m_door_dir, m_code;
  bit m_arr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_floor = RF; m_dir = 0; m_prog = 0;
    m_door_pos = 0; m_door_dir = 0; m_code = 0; m_arr = 0;
  endtask

  task automatic model_step(input bit u, input bit d, input bit o, input bit c);
    m_arr = 0;
    if (m_code != 0) return;
    if (int'(u) + int'(d) + int'(o) + int'(c) > 1) begin
      m_code = 1;
    end else if (m_door_dir != 0 || m_door_pos != 0) begin
      if (u || d) m_code = 2;
      else if (m_door_dir == 1) begin
        m_door_pos++;
        if (m_door_pos == DT) m_door_dir = 0;
      end else if (m_door_dir == 0) begin
        if (c) begin m_door_dir = -1; m_door_pos = DT; end
      end else if (o) begin
        m_door_dir = 1; m_door_pos = 0;
      end else begin
        m_door_pos--;
        if (m_door_pos == 0) m_door_dir = 0;
      end
    end else if (m_dir != 0 && m_prog != 0) begin
      if ((m_dir == 1 && u) || (m_dir == -1 && d)) begin
        m_prog++;
        if (m_prog == TPF) begin
          m_floor += m_dir; m_prog = 0; m_arr = 1;
        end
      end else m_code = 4;
    end else if (u) begin
      if (m_floor == NF - 1) m_code = 3;
      else if (m_dir == 1) m_prog = 1;
      else begin m_dir = 1; m_prog = 0; end
    end else if (d) begin
      if (m_floor == 0) m_code = 3;
      else if (m_dir == -1) m_prog = 1;
      else begin m_dir = -1; m_prog = 0; end
    end else if (o) begin
      m_dir = 0; m_door_dir = 1; m_door_pos = 0;
    end else begin
      m_dir = 0;
    end
  endtask

  task automatic check_all(input string where);
    bit flt;
    flt = (m_code != 0);
    chk({where, " floor"}, 32'(floor), m_floor);
    chk({where, " arrived"}, 32'(arrived), 32'(m_arr));
    chk({where, " moving"}, 32'(moving), 32'(!flt && m_dir != 0));
    chk({where, " door_open"}, 32'(door_open), 32'(!flt && m_door_dir == 0 && m_door_pos == DT));
    chk({where, " door_closed"}, 32'(door_closed), 32'(!flt && m_door_dir == 0 && m_door_pos == 0));
    chk({where, " fault"}, 32'(fault), 32'(flt));
    chk({where, " fault_code"}, 32'(fault_code), m_code);
  endtask

  task automatic step(input string where, input bit r, input bit u, input bit d, input bit o,
                      input bit c);
    rst = r; up = u; down = d; open = o; close = c;
    @(posedge clk);
    if (r) model_reset();
    else model_step(u, d, o, c);
    #1;
    check_all(where);
  endtask

  initial begin
    int r;
    int cmd;
    logic [3:0] mc;
    model_reset();
    rst = 1'b1; up = 1'b0; down = 1'b0; open = 1'b0; close = 1'b0;

    step("reset", 1, 0, 0, 0, 0);
    step("reset", 1, 0, 0, 0, 0);
    chk("reset door_closed", 32'(door_closed), 1);

    // Sustained up: floor 1 after 5 edges, floor 2 after 9.
    for (int i = 1; i <= 9; i++) begin
      step("up_run", 0, 1, 0, 0, 0);
      if (i == 5) begin
        chk("up floor1", 32'(floor), 1);
        chk("up arrived1", 32'(arrived), 1);
      end
    end
    chk("up floor2", 32'(floor), 2);

    // Open at the boundary, then close back to STOP.
    step("open", 0, 0, 0, 1, 0);
    for (int i = 0; i < DT; i++) step("opening", 0, 0, 0, 0, 0);
    chk("door fully open", 32'(door_open), 1);
    step("close", 0, 0, 0, 0, 1);
    for (int i = 0; i < DT; i++) step("closing", 0, 0, 0, 0, 0);
    chk("door shut", 32'(door_closed), 1);

    // Reversal during closing.
    step("open2", 0, 0, 0, 1, 0);
    for (int i = 0; i < DT; i++) step("opening2", 0, 0, 0, 0, 0);
    step("close2", 0, 0, 0, 0, 1);
    step("closing2", 0, 0, 0, 0, 0);
    step("reverse", 0, 0, 0, 1, 0);
    for (int i = 0; i < DT; i++) begin
      chk("reverse no stop", 32'(door_closed), 0);
      step("reopening", 0, 0, 0, 0, 0);
    end
    chk("reverse open", 32'(door_open), 1);
    step("close3", 0, 0, 0, 0, 1);
    for (int i = 0; i < DT; i++) step("closing3", 0, 0, 0, 0, 0);

    // Travel limit at the top floor.
    for (int i = 0; i < 200 && m_floor != NF - 1; i++) step("to_top", 0, 1, 0, 0, 0);
    step("top_stop", 0, 0, 0, 0, 0);
    step("top_up", 0, 1, 0, 0, 0);
    chk("limit code", 32'(fault_code), 3);
    chk("limit floor", 32'(floor), NF - 1);
    for (int i = 0; i < 4; i++) step("fault_hold", 0, i[0], i[1], !i[0], 0);
    step("limit_rst", 1, 0, 0, 0, 0);
    chk("limit rst floor", 32'(floor), 0);

    // Stop between floors while descending.
    for (int i = 0; i < TPF + 1; i++) step("climb", 0, 1, 0, 0, 0);
    step("halt", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("descend", 0, 0, 1, 0, 0);
    step("drop_down", 0, 0, 0, 0, 0);
    chk("stray code", 32'(fault_code), 4);
    step("rst", 1, 0, 0, 0, 0);

    // Door interlock, then multi-command.
    step("open4", 0, 0, 0, 1, 0);
    for (int i = 0; i < DT; i++) step("opening4", 0, 0, 0, 0, 0);
    step("up_in_door", 0, 1, 0, 0, 0);
    chk("door code", 32'(fault_code), 2);
    step("rst", 1, 0, 0, 0, 0);
    step("multi", 0, 1, 0, 1, 0);
    chk("multi code", 32'(fault_code), 1);
    step("rst", 1, 0, 0, 0, 0);

    // Reset mid-move at floor 3, cnt 2.
    for (int i = 0; i < 100 && !(m_floor == 3 && m_prog == 2); i++) step("to3", 0, 1, 0, 0, 0);
    step("mid_rst", 1, 1, 0, 0, 0);
    chk("mid_rst floor", 32'(floor), 0);
    chk("mid_rst arrived", 32'(arrived), 0);

    // Random commands with persistence; occasional overlapping commands and resets.
    cmd = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if ((m_code != 0 && $urandom_range(0, 3) == 0) || r == 0) begin
        step("rnd_rst", 1, 0, 0, 0, 0);
      end else if (r < 3) begin
        mc = 4'($urandom_range(0, 15));
        if ($countones(mc) < 2) mc = mc | 4'b1010;
        step("rnd_multi", 0, mc[0], mc[1], mc[2], mc[3]);
      end else begin
        if (r < 22) cmd = $urandom_range(0, 4);
        step("rnd", 0, cmd == 1, cmd == 2, cmd == 3, cmd == 4);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lift_car_model.md
Name: lift_car_model

Overview:
- Behavioural responder for the elevator controller's command outputs: consumes one-hot up/down/open/close commands, models car travel between floors and door motion with cycle counters, and returns floor position, arrival and door status.
- Sits on the far side of the controller interface. Used as the plant in closed-loop simulation and as a safety interlock checker that flags illegal command sequences.

Parameters:
- NUM_FLOORS, 8, number of floors (G..7); top floor is NUM_FLOORS-1.
- FLOOR_W, 3, width of the floor index.
- TICKS_PER_FLOOR, 4, cycles of sustained up/down per one-floor move; minimum 2.
- DOOR_TICKS, 3, cycles for the door to fully open or close; minimum 2.
- CNT_W, 7, motion/door counter width; must hold max(TICKS_PER_FLOOR, DOOR_TICKS).
- RESET_FLOOR, 0, floor after reset.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- up  in  1  controller command: move up
- down  in  1  controller command: move down
- open  in  1  controller command: open door
- close  in  1  controller command: close door
- floor  out  FLOOR_W  current car floor, registered
- arrived  out  1  one-cycle pulse on the cycle after floor changes
- moving  out  1  car in MOVE_UP or MOVE_DOWN
- door_open  out  1  door fully open (DOOR_OPEN)
- door_closed  out  1  door fully closed (STOP, MOVE_UP, MOVE_DOWN)
- fault  out  1  sticky fault indication
- fault_code  out  3  0 none, 1 multi-command, 2 door interlock, 3 travel limit, 4 stop between floors

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset, and rst held high at any time including mid-move: state=STOP, floor=RESET_FLOOR, cnt=0, arrived=0, moving=0, door_open=0, door_closed=1, fault=0, fault_code=0.
- States: STOP, MOVE_UP, MOVE_DOWN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING, FAULT.
- Priority check every cycle in every non-FAULT state: if more than one command is high, go to FAULT with code 1. This overrides all other transitions.
- STOP:
  - up: go to MOVE_UP (cnt=0). At the top floor, go to FAULT with code 3 instead.
  - down: go to MOVE_DOWN (cnt=0). At floor 0, go to FAULT with code 3 instead.
  - open: go to DOOR_OPENING (cnt=0).
  - close or no command: stay in STOP.
- MOVE_UP:
  - Each cycle with up high: cnt+1.
  - When cnt==TICKS_PER_FLOOR-1 with up high: floor+1, cnt=0, arrived=1 for the next cycle.
  - When cnt==0 (at a floor boundary), commands decode exactly as in STOP; up continues the move. up at cnt==0 on the top floor goes to FAULT with code 3.
  - up low with cnt!=0: FAULT, code 4.
- MOVE_DOWN: mirror of MOVE_UP with floor-1; the floor-0 limit gives code 3.
- DOOR_OPENING:
  - cnt+1 each cycle; open need not be held.
  - When cnt==DOOR_TICKS-1: go to DOOR_OPEN, cnt=0.
  - close is ignored.
  - up or down: FAULT, code 2.
- DOOR_OPEN:
  - close: go to DOOR_CLOSING (cnt=0).
  - open or no command: stay.
  - up or down: FAULT, code 2.
- DOOR_CLOSING:
  - cnt+1 each cycle.
  - When cnt==DOOR_TICKS-1: go to STOP.
  - open: go to DOOR_OPENING with cnt=0 (door reversal; wins over completion in the same cycle).
  - up or down: FAULT, code 2.
- FAULT:
  - Absorbing until rst.
  - floor held; moving=0, arrived=0; door_open and door_closed both 0 (door state unknown); fault=1; fault_code holds the first cause.
- arrived:
  - Exactly one cycle per floor change.
  - Never asserted in the same cycle as a fault entry.
- Floor arithmetic is unsigned FLOOR_W. Wrap is impossible because the limit checks run before any increment or decrement.

Test Plan:
- Reset, then up held from cycle 1 with TICKS_PER_FLOOR=4 -> MOVE_UP after edge 1; floor=1 after edge 5 with arrived=1 for one cycle; floor=2 after edge 9; moving=1 and door_closed=1 throughout.
- At floor 2 in MOVE_UP, cnt==0: drop up, raise open -> DOOR_OPENING. door_open=1 after 3 cycles. Then close -> door_closed=1 and state STOP 3 cycles later.
- DOOR_CLOSING with cnt=1: pulse open -> DOOR_OPENING with cnt=0. door_open=1 exactly 3 cycles later, and no STOP is visited.
- Floor 7, STOP: assert up -> fault=1, fault_code=3, floor stays 7. Commands are then ignored until rst, which restores floor=0, fault=0.
- MOVE_DOWN with cnt=2: deassert down -> fault_code=4. Separately, in DOOR_OPEN assert up -> fault_code=2. Separately, assert up and open together from STOP -> fault_code=1.
- rst asserted mid-move (cnt=2, floor=3) -> the next cycle shows all reset values, with floor=0 and arrived=0.
